input_conditioner: RTL
======================

# input_conditioner

Turns raw board push-buttons into clean, frame-aligned commands for the player movement/attack state machine. Each input is synchronised, debounced and then sampled once per 60 Hz frame tick. The movement and attack outputs therefore only change at frame boundaries and are stable for the whole frame. Left/right conflicts resolve to neutral, and an attack press becomes a single one-frame command.

## Interface
- `DEBOUNCE_CYCLES`, 500000: consecutive `clk` cycles a synchronised input must differ from its debounced state before that state flips (10 ms at 50 MHz). Legal range ≥ 2.
- `CNT_W`, 19: width of each debounce counter. Must satisfy 2^CNT_W ≥ DEBOUNCE_CYCLES.
- `BTN_ACTIVE_LOW`, 1: 1 means a pin reads 0 when pressed; 0 means a pin reads 1 when pressed.
- `clk`  in  1  system clock; all state is on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `frame_tick`  in  1  one-`clk`-cycle pulse at 60 Hz, synchronous to `clk`.
- `key_left_raw`  in  1  raw left pin, asynchronous.
- `key_right_raw`  in  1  raw right pin, asynchronous.
- `key_attack_raw`  in  1  raw attack pin, asynchronous.
- `btn_left`  out  1  left held, frame-aligned level.
- `btn_right`  out  1  right held, frame-aligned level.
- `btn_attack`  out  1  attack command, high for exactly one frame per press.
- `attack_dropped`  out  1  sticky flag: a second attack press arrived while one was already pending in the same frame. Cleared only by reset.

## Operation
- Polarity: each raw pin is converted to pressed=1 according to `BTN_ACTIVE_LOW` before synchronisation.
- Synchroniser: two flops per input.
  - Reset value corresponds to "released".
- Debounce, per input. Debounced state `db` resets to 0; counter `cnt` resets to 0.
  - When sync == db: cnt ← 0.
  - When sync ≠ db and cnt == DEBOUNCE_CYCLES−1: db ← sync and cnt ← 0.
  - Otherwise: cnt ← cnt+1.
  - Any glitch shorter than DEBOUNCE_CYCLES cycles is discarded.
- Direction resolution (combinational from `db`):
  - Left only gives L=1, R=0.
  - Right only gives L=0, R=1.
  - Both or neither gives L=0, R=0.
- Attack edge detection: `press` = `db_attack` rising, i.e. 0→1 versus the previous cycle's value.
- Attack pending register `pend`:
  - Set on `press` when no `frame_tick` occurs in the same cycle.
  - Cleared on every `frame_tick`.
  - If `press` occurs while `pend` is already 1 (and no tick): `attack_dropped` ← 1 and `pend` stays 1.
- On a `frame_tick` cycle:
  - `btn_left` ← resolved L.
  - `btn_right` ← resolved R.
  - `btn_attack` ← `pend` OR `press`; a press coinciding with the tick is consumed by this tick.
  - `pend` ← 0.
- Between ticks all three `btn_*` outputs hold their values.
- A held attack button never re-triggers. A new press needs a debounced release followed by a debounced press.

## Timing
- Reset, asserted asynchronously: all outputs 0, all `db`, `cnt`, `pend` and synchroniser flops go to the released state immediately. Reset mid-frame discards any pending attack and any partial debounce count.
- After reset release, outputs first change on the cycle after the first `frame_tick`.
- Raw edge to `db` change: 2 synchroniser cycles, plus DEBOUNCE_CYCLES cycles, for a clean edge.
- `db` change to output: the first `frame_tick` at or after the change. The output becomes visible on the `clk` edge that samples the tick, so it is registered and one cycle after the tick cycle.
- `btn_attack` stays high from one tick-sampling edge to the next, i.e. exactly one frame period.
- A `frame_tick` asserted on consecutive cycles is treated as two ticks; the block does not guard against this.
- The counter never wraps: it saturates by construction at DEBOUNCE_CYCLES−1 before resetting.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4, BTN_ACTIVE_LOW=1 and `frame_tick` every 20 cycles unless stated.
- Reset: hold `reset_n`=0 with all pins 0 (pressed) across 3 ticks. All outputs must stay 0 and `attack_dropped` must stay 0.
- Bounce rejection: pulse `key_right_raw` low for 3 cycles, 5 times. `btn_right` must never assert.
- Clean press: drive `key_right_raw` low 10 cycles before a tick.
  - `btn_right`=1 from the cycle after that tick.
  - `btn_left`=0.
  - After release, `btn_right` returns to 0 after the first tick that is ≥6 cycles after the release.
- Attack pulse: hold `key_attack_raw` low across 4 ticks. `btn_attack`=1 for exactly 20 cycles (one frame), then 0.
- Same-cycle press and tick: align the debounced press with the tick cycle. `btn_attack` is high for the following frame only.
- Conflict and drop:
  - Hold left and right: both outputs are 0.
  - Release left: `btn_right`=1 after the next qualifying tick.
  - Two debounced attack presses between ticks: `btn_attack` high for one frame only and `attack_dropped`=1.
  - A mid-frame reset then clears everything.

Source files
------------

// File: rtl/input_conditioner.sv
// Push-button front end: per-pin polarity fix, 2-flop sync and debounce, then
// frame-aligned direction levels and a one-frame attack command.

module input_conditioner_lane #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 19,
    parameter bit BTN_ACTIVE_LOW  = 1'b1
) (
    input  logic clk,
    input  logic reset_n,
    input  logic raw,
    output logic db
);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             pressed;
    logic [1:0]       sync;
    logic [CNT_W-1:0] cnt;

    // Normalise to pressed=1 ahead of the synchroniser so its reset value means released.
    assign pressed = BTN_ACTIVE_LOW ? ~raw : raw;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync <= '0;
        end else begin
            sync <= {sync[0], pressed};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            db  <= 1'b0;
            cnt <= '0;
        end else if (sync[1] == db) begin
            cnt <= '0;
        end else if (cnt == CNT_LAST) begin
            db  <= sync[1];
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end
endmodule

module input_conditioner #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 19,
    parameter bit BTN_ACTIVE_LOW  = 1'b1
) (
    input  logic clk,
    input  logic reset_n,
    input  logic frame_tick,
    input  logic key_left_raw,
    input  logic key_right_raw,
    input  logic key_attack_raw,
    output logic btn_left,
    output logic btn_right,
    output logic btn_attack,
    output logic attack_dropped
);
    localparam int NUM_LANES = 3;
    localparam int L_LEFT    = 0;
    localparam int L_RIGHT   = 1;
    localparam int L_ATK     = 2;

    logic [NUM_LANES-1:0] raw;
    logic [NUM_LANES-1:0] db;
    logic                 db_atk_q;
    logic                 press;
    logic                 pend;
    logic                 dir_l;
    logic                 dir_r;

    assign raw = {key_attack_raw, key_right_raw, key_left_raw};

    generate
        for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
            input_conditioner_lane #(
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
                .CNT_W           (CNT_W),
                .BTN_ACTIVE_LOW  (BTN_ACTIVE_LOW)
            ) u_lane (
                .clk     (clk),
                .reset_n (reset_n),
                .raw     (raw[g]),
                .db      (db[g])
            );
        end
    endgenerate

    // Opposing directions cancel to neutral.
    assign dir_l = db[L_LEFT]  & ~db[L_RIGHT];
    assign dir_r = db[L_RIGHT] & ~db[L_LEFT];
    assign press = db[L_ATK]   & ~db_atk_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            db_atk_q       <= 1'b0;
            pend           <= 1'b0;
            btn_left       <= 1'b0;
            btn_right      <= 1'b0;
            btn_attack     <= 1'b0;
            attack_dropped <= 1'b0;
        end else begin
            db_atk_q <= db[L_ATK];
            if (frame_tick) begin
                // A press landing on the tick is consumed here rather than pended.
                btn_left   <= dir_l;
                btn_right  <= dir_r;
                btn_attack <= pend | press;
                pend       <= 1'b0;
            end else if (press) begin
                if (pend) attack_dropped <= 1'b1;
                pend <= 1'b1;
            end
        end
    end
endmodule
